pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter register plus next-PC selection for the single-cycle/multi-cycle MIPS datapath.
//  Generalises the fixed 32-bit jump-target concatenation: parametrised widths, branch/jump/jr targets,
//  stall hold and an optional one-instruction branch delay slot. Sits between control unit and instruction memory.
// PARAMETERS
//  PC_WIDTH     32   PC/address width; must be >= INDEX_WIDTH+ALIGN_BITS+1
//  INDEX_WIDTH  26   jump instruction index field width
//  IMM_WIDTH    16   branch immediate width (sign-extended)
//  ALIGN_BITS   2    log2(instruction bytes); sequential increment = 1<<ALIGN_BITS
//  RESET_PC     0    PC value loaded on reset
//  DELAY_SLOT   0    0: redirect next cycle; 1: execute one delay-slot instruction before redirect
// PORTS
//  clk              in   1            clock, all state on rising edge
//  reset            in   1            synchronous, active-high
//  stall            in   1            hold PC and state this cycle
//  jr_en            in   1            register-indirect jump request
//  jump_en          in   1            absolute jump request
//  branch_taken     in   1            conditional branch resolved taken
//  instr_index      in   INDEX_WIDTH  jump index field
//  imm              in   IMM_WIDTH    branch offset, in instructions
//  jr_addr          in   PC_WIDTH     jr target
//  pc               out  PC_WIDTH     current PC (registered)
//  pc_plus_4        out  PC_WIDTH     pc + (1<<ALIGN_BITS), combinational
//  jump_pc          out  PC_WIDTH     {pc_plus_4[PC_WIDTH-1:INDEX_WIDTH+ALIGN_BITS], instr_index, ALIGN_BITS'b0}
//  redirect_pending out  1            1 while a delayed redirect is held (DELAY_SLOT=1 only)
//  misaligned       out  1            registered: last accepted jr had nonzero low ALIGN_BITS
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1): pc=RESET_PC, redirect_pending=0, misaligned=0, target_q=0; beats stall.
//  Arithmetic mod 2^PC_WIDTH: pc_plus_4 and branch target wrap silently (0xFFFF_FFFC+4 -> 0).
//  branch_target = pc_plus_4 + (sext(imm) << ALIGN_BITS).
//  jr target = jr_addr with low ALIGN_BITS forced 0; misaligned<=|jr_addr[ALIGN_BITS-1:0] when jr accepted.
//  Priority when several requests set same cycle: jr_en > jump_en > branch_taken > sequential.
//  stall=1: pc, redirect_pending, target_q, misaligned hold; requests that cycle are NOT captured.
//  DELAY_SLOT=0: no state besides pc; accepted request -> pc<=target at next edge (latency 1), else pc<=pc_plus_4.
//  DELAY_SLOT=1: FSM IDLE/PENDING.
//   IDLE, request accepted: target_q<=target, pc<=pc_plus_4 (delay slot), ->PENDING, redirect_pending=1.
//   IDLE, no request: pc<=pc_plus_4.
//   PENDING, !stall: pc<=target_q, ->IDLE; any request this cycle is ignored (redirect in delay slot unsupported).
//   PENDING, stall: hold; target survives any number of stall cycles.
//  redirect_pending is state-decoded (registered); tied 0 when DELAY_SLOT=0.
//  Reset mid-PENDING discards target_q; pc returns to RESET_PC.
//  jump_pc always uses upper bits of current pc_plus_4 (region crossing at 0x0FFF_FFFC uses new region).
// TESTING (defaults unless stated)
//  T1 reset then 4 idle cycles -> pc 0,4,8,12; misaligned=0; redirect_pending=0.
//  T2 pc=0x0040_0010, jump_en, instr_index=0x010_0000 -> next pc=0x0040_0000; pc=0xF000_0000 same -> 0xF040_0000.
//  T3 pc=0x100, branch_taken, imm=0xFFFF -> next pc=0x100; imm=0x0003 -> 0x110; jr_en+jump_en together -> jr wins.
//  T4 jr_en, jr_addr=0x1003 -> pc=0x1000, misaligned=1 next cycle; following jr 0x2000 clears it.
//  T5 DELAY_SLOT=1, pc=0x20, jump to 0x400 -> pc 0x24 (pending=1), stall 3 cycles holds 0x24, then 0x400; jump in slot ignored.
//  T6 reset asserted while PENDING with stall=1 -> pc=RESET_PC, pending=0; PC_WIDTH=16 wrap 0xFFFC -> 0x0000.

Source files
------------

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter register and next-PC selection for a MIPS-style datapath.
//   Produces the sequential PC, the absolute jump target and the branch target.
//   It also accepts register-indirect jumps (jr). The sequencer supports stall
//   hold and, optionally, a single branch delay slot before a redirect lands.
//
// Ports
//   clk              in   clock, all state updates on the rising edge
//   reset            in   synchronous, active-high; overrides stall
//   stall            in   hold all state; requests this cycle are not captured
//   jr_en            in   register-indirect jump request (highest priority)
//   jump_en          in   absolute jump request
//   branch_taken     in   conditional branch resolved taken (lowest priority)
//   instr_index      in   jump instruction index field
//   imm              in   branch offset in instructions (sign-extended)
//   jr_addr          in   jr target address
//   pc               out  current PC (registered)
//   pc_plus_4        out  pc + one instruction (combinational, wraps)
//   jump_pc          out  {pc_plus_4 upper bits, instr_index, alignment zeros}
//   redirect_pending out  a delayed redirect is held (DELAY_SLOT=1 only)
//   misaligned       out  last accepted jr had nonzero alignment bits
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned           PC_WIDTH    = 32,
    parameter int unsigned           INDEX_WIDTH = 26,
    parameter int unsigned           IMM_WIDTH   = 16,
    parameter int unsigned           ALIGN_BITS  = 2,
    parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0,
    parameter bit                    DELAY_SLOT  = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   jr_en,
    input  logic                   jump_en,
    input  logic                   branch_taken,
    input  logic [INDEX_WIDTH-1:0] instr_index,
    input  logic [IMM_WIDTH-1:0]   imm,
    input  logic [PC_WIDTH-1:0]    jr_addr,
    output logic [PC_WIDTH-1:0]    pc,
    output logic [PC_WIDTH-1:0]    pc_plus_4,
    output logic [PC_WIDTH-1:0]    jump_pc,
    output logic                   redirect_pending,
    output logic                   misaligned
);

    // One instruction worth of bytes, and masks derived from it.
    localparam logic [PC_WIDTH-1:0] ONE         = PC_WIDTH'(1);
    localparam logic [PC_WIDTH-1:0] INC         = ONE << ALIGN_BITS;
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK  = INC - ONE;
    // Bits of pc_plus_4 that survive into a jump target (the "region").
    localparam logic [PC_WIDTH-1:0] REGION_MASK =
        ~((ONE << (INDEX_WIDTH + ALIGN_BITS)) - ONE);

    typedef enum logic {
        IDLE,
        PENDING
    } state_e;

    state_e                state_q;
    logic [PC_WIDTH-1:0]   pc_q;
    logic [PC_WIDTH-1:0]   target_q;
    logic                  misaligned_q;

    logic [PC_WIDTH-1:0]   imm_ext;
    logic [PC_WIDTH-1:0]   branch_pc;
    logic [PC_WIDTH-1:0]   jr_pc;
    logic                  jr_misaligned;
    logic                  req_valid;
    logic [PC_WIDTH-1:0]   target_d;

    // Target datapath; all adds wrap modulo 2^PC_WIDTH.
    assign pc_plus_4     = pc_q + INC;
    assign jump_pc       = (pc_plus_4 & REGION_MASK) | (PC_WIDTH'(instr_index) << ALIGN_BITS);
    assign imm_ext       = PC_WIDTH'(signed'(imm));
    assign branch_pc     = pc_plus_4 + (imm_ext << ALIGN_BITS);
    assign jr_pc         = jr_addr & ~ALIGN_MASK;
    assign jr_misaligned = |(jr_addr & ALIGN_MASK);
    assign req_valid     = jr_en | jump_en | branch_taken;

    // Fixed priority: jr > jump > branch.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        target_d = pc_plus_4;
        if (jr_en) begin
            target_d = jr_pc;
        end else if (jump_en) begin
            target_d = jump_pc;
        end else if (branch_taken) begin
            target_d = branch_pc;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            state_q      <= IDLE;
            target_q     <= '0;
            misaligned_q <= 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        if (jr_en) begin
                            misaligned_q <= jr_misaligned;
                        end
                        if (DELAY_SLOT) begin
                            // Execute the slot instruction first; redirect next.
                            target_q <= target_d;
                            pc_q     <= pc_plus_4;
                            state_q  <= PENDING;
                        end else begin
                            pc_q <= target_d;
                        end
                    end else begin
                        pc_q <= pc_plus_4;
                    end
                end
                PENDING: begin
                    // Requests issued from the delay slot are dropped.
                    pc_q    <= target_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pc               = pc_q;
    assign misaligned       = misaligned_q;
    assign redirect_pending = DELAY_SLOT && (state_q == PENDING);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer. Three instances share the stimulus:
//   0: defaults (32-bit, no delay slot)
//   1: defaults with DELAY_SLOT=1
//   2: PC_WIDTH=16, INDEX_WIDTH=10, RESET_PC=0xFFF8, no delay slot
// A reference model derived from the sequencing rules predicts every output,
// and one compare process checks all instances on each falling edge.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        jr_en;
    logic        jump_en;
    logic        branch_taken;
    logic [25:0] instr_index;
    logic [15:0] imm;
    logic [31:0] jr_addr;

    logic [31:0] pc_a, p4_a, jpc_a;
    logic [31:0] pc_b, p4_b, jpc_b;
    logic [15:0] pc_c, p4_c, jpc_c;
    logic        pend_a, pend_b, pend_c;
    logic        mis_a, mis_b, mis_c;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer u_a (
        .clk(clk), .reset(reset), .stall(stall), .jr_en(jr_en), .jump_en(jump_en),
        .branch_taken(branch_taken), .instr_index(instr_index), .imm(imm),
        .jr_addr(jr_addr), .pc(pc_a), .pc_plus_4(p4_a), .jump_pc(jpc_a),
        .redirect_pending(pend_a), .misaligned(mis_a)
    );

    pc_sequencer #(.DELAY_SLOT(1'b1)) u_b (
        .clk(clk), .reset(reset), .stall(stall), .jr_en(jr_en), .jump_en(jump_en),
        .branch_taken(branch_taken), .instr_index(instr_index), .imm(imm),
        .jr_addr(jr_addr), .pc(pc_b), .pc_plus_4(p4_b), .jump_pc(jpc_b),
        .redirect_pending(pend_b), .misaligned(mis_b)
    );

    pc_sequencer #(.PC_WIDTH(16), .INDEX_WIDTH(10), .RESET_PC(16'hFFF8)) u_c (
        .clk(clk), .reset(reset), .stall(stall), .jr_en(jr_en), .jump_en(jump_en),
        .branch_taken(branch_taken), .instr_index(instr_index[9:0]), .imm(imm),
        .jr_addr(jr_addr[15:0]), .pc(pc_c), .pc_plus_4(p4_c), .jump_pc(jpc_c),
        .redirect_pending(pend_c), .misaligned(mis_c)
    );

    logic [31:0] d_pc[3], d_p4[3], d_jpc[3];
    logic        d_pend[3], d_mis[3];
    assign d_pc[0]  = pc_a;          assign d_pc[1]  = pc_b;          assign d_pc[2]  = {16'h0, pc_c};
    assign d_p4[0]  = p4_a;          assign d_p4[1]  = p4_b;          assign d_p4[2]  = {16'h0, p4_c};
    assign d_jpc[0] = jpc_a;         assign d_jpc[1] = jpc_b;         assign d_jpc[2] = {16'h0, jpc_c};
    assign d_pend[0] = pend_a;       assign d_pend[1] = pend_b;       assign d_pend[2] = pend_c;
    assign d_mis[0]  = mis_a;        assign d_mis[1]  = mis_b;        assign d_mis[2]  = mis_c;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic        pend;
        logic [31:0] tgt;
        logic        mis;
    } model_t;

    model_t m[3];

    function automatic logic [31:0] addr_mask(int k);
        return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] reset_pc(int k);
        return (k == 2) ? 32'h0000_FFF8 : 32'h0;
    endfunction

    function automatic logic [31:0] plus4(int k, logic [31:0] p);
        return (p + 32'd4) & addr_mask(k);
    endfunction

    // Jump target: keep the bits of pc+4 above the index field, insert index*4.
    function automatic logic [31:0] jump_of(int k, logic [31:0] p);
        int          iw;
        logic [31:0] region;
        logic [31:0] idx;
        iw     = (k == 2) ? 10 : 26;
        region = (plus4(k, p) >> (iw + 2)) << (iw + 2);
        idx    = 32'(instr_index) & ((32'd1 << iw) - 32'd1);
        return (region | (idx * 32'd4)) & addr_mask(k);
    endfunction

    function automatic logic [31:0] target_of(int k, logic [31:0] p);
        logic [31:0] sext;
        sext = {{16{imm[15]}}, imm};
        if (jr_en)        return jr_addr & addr_mask(k) & ~32'h3;
        else if (jump_en) return jump_of(k, p);
        else              return (plus4(k, p) + sext * 32'd4) & addr_mask(k);
    endfunction

    function automatic model_t step(int k, model_t s);
        model_t n;
        n = s;
        if (reset) begin
            n.pc = reset_pc(k); n.pend = 1'b0; n.tgt = 32'h0; n.mis = 1'b0;
        end else if (stall) begin
            n = s;
        end else if (s.pend) begin
            n.pc = s.tgt; n.pend = 1'b0;
        end else if (jr_en || jump_en || branch_taken) begin
            if (jr_en) n.mis = (jr_addr[1:0] != 2'b00);
            if (k == 1) begin
                n.tgt = target_of(k, s.pc); n.pc = plus4(k, s.pc); n.pend = 1'b1;
            end else begin
                n.pc = target_of(k, s.pc);
            end
        end else begin
            n.pc = plus4(k, s.pc);
        end
        return n;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) m[k] <= step(k, m[k]);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("pc[%0d]", k), d_pc[k], m[k].pc);
                check($sformatf("pc_plus_4[%0d]", k), d_p4[k], plus4(k, m[k].pc));
                check($sformatf("jump_pc[%0d]", k), d_jpc[k], jump_of(k, m[k].pc));
                check($sformatf("pending[%0d]", k), 32'(d_pend[k]), 32'(m[k].pend));
                check($sformatf("misaligned[%0d]", k), 32'(d_mis[k]), 32'(m[k].mis));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; jr_en = 1'b0; jump_en = 1'b0; branch_taken = 1'b0;
    endtask

    task automatic do_jr(input logic [31:0] a);
        idle(); jr_en = 1'b1; jr_addr = a; tick();
    endtask

    task automatic do_jump(input logic [25:0] idx);
        idle(); jump_en = 1'b1; instr_index = idx; tick();
    endtask

    initial begin
        idle();
        reset = 1'b1; instr_index = '0; imm = '0; jr_addr = '0;
        tick();
        check_en = 1'b1;

        // T1: reset value and sequential increments; 16-bit wrap.
        check("t1_reset_pc", pc_a, 32'h0);
        check("t1_reset_pc16", {16'h0, pc_c}, 32'h0000_FFF8);
        idle();
        tick();
        check("t1_pc4", pc_a, 32'h4);
        check("t1_pc16_fffc", {16'h0, pc_c}, 32'h0000_FFFC);
        tick();
        check("t1_pc16_wrap", {16'h0, pc_c}, 32'h0);
        tick();
        check("t1_pc12", pc_a, 32'hC);
        check("t1_mis", 32'(mis_a), 32'h0);
        check("t1_pend", 32'(pend_b), 32'h0);

        // T2: jump keeps the region bits of pc+4.
        do_jr(32'h0040_0010);
        check("t2_jr_setup", pc_a, 32'h0040_0010);
        do_jump(26'h010_0000);
        check("t2_jump_low", pc_a, 32'h0040_0000);
        do_jr(32'hF000_0000);
        do_jump(26'h010_0000);
        check("t2_jump_high", pc_a, 32'hF040_0000);

        // T3: branches and priority.
        do_jr(32'h0000_0100);
        idle(); branch_taken = 1'b1; imm = 16'hFFFF; tick();
        check("t3_branch_back", pc_a, 32'h0000_0100);
        imm = 16'h0003; tick();
        check("t3_branch_fwd", pc_a, 32'h0000_0110);
        idle(); jr_en = 1'b1; jump_en = 1'b1; jr_addr = 32'h0000_0200; instr_index = 26'h3; tick();
        check("t3_jr_priority", pc_a, 32'h0000_0200);

        // T4: misaligned flag tracks the last jr.
        do_jr(32'h0000_1003);
        check("t4_jr_aligned_pc", pc_a, 32'h0000_1000);
        check("t4_mis_set", 32'(mis_a), 32'h1);
        do_jr(32'h0000_2000);
        check("t4_mis_clear", 32'(mis_a), 32'h0);

        // T5: delay slot on instance 1.
        idle(); reset = 1'b1; tick();
        idle();
        repeat (8) tick();
        check("t5_pc_start", pc_b, 32'h0000_0020);
        do_jump(26'h100);
        check("t5_slot_pc", pc_b, 32'h0000_0024);
        check("t5_pending", 32'(pend_b), 32'h1);
        idle(); stall = 1'b1; jump_en = 1'b1; instr_index = 26'h3FF;
        repeat (3) begin
            tick();
            check("t5_stall_hold", pc_b, 32'h0000_0024);
        end
        idle(); jump_en = 1'b1; instr_index = 26'h200; tick();
        check("t5_redirect", pc_b, 32'h0000_0400);
        check("t5_pending_clear", 32'(pend_b), 32'h0);
        idle(); tick();
        check("t5_slot_jump_ignored", pc_b, 32'h0000_0404);

        // T6: reset beats stall while pending.
        do_jump(26'h100);
        check("t6_pending", 32'(pend_b), 32'h1);
        idle(); stall = 1'b1; reset = 1'b1; tick();
        check("t6_reset_pc", pc_b, 32'h0);
        check("t6_reset_pending", 32'(pend_b), 32'h0);
        idle();

        // Randomized traffic, checked by the model on every cycle.
        for (int i = 0; i < 1500; i++) begin
            reset        = ($urandom_range(0, 63) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            jr_en        = ($urandom_range(0, 7) == 0);
            jump_en      = ($urandom_range(0, 5) == 0);
            branch_taken = ($urandom_range(0, 4) == 0);
            instr_index  = 26'($urandom);
            imm          = 16'($urandom);
            jr_addr      = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : $urandom;
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
